// File: rtl/crc_stream_if.sv
// Word stream into the CRC engine plus the held result coming back out.
// The producer side drives start and the word handshake; the engine drives
// in_ready, busy and the registered result.
interface crc_stream_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WIDTH  = 8
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              busy;
    logic              out_valid;
    logic [WIDTH-1:0]  out_crc;

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, busy, out_valid, out_crc
    );

    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, busy, out_valid, out_crc
    );
endinterface

// File: rtl/crc_stream.sv
// Parametrised multi-word CRC engine. Words arrive on a valid/ready stream,
// each one is folded BITS_PER_CLK bits per cycle into the CRC register, and
// the final (optionally reflected, XORed) value is held until the next start.
module crc_stream #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] POLY         = 'h9B,
    parameter logic [WIDTH-1:0] INIT         = '0,
    parameter logic [WIDTH-1:0] XOROUT       = '0,
    parameter int unsigned      DATA_W       = 8,
    parameter int unsigned      BITS_PER_CLK = 1,
    parameter bit               REFIN        = 1'b0,
    parameter bit               REFOUT       = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    crc_stream_if.slave   bus
);

    localparam int unsigned N     = DATA_W / BITS_PER_CLK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    // A word must split into a whole number of fold steps.
    generate
        if ((BITS_PER_CLK == 0) || (DATA_W % BITS_PER_CLK != 0)) begin : g_bad_cfg
            $error("crc_stream: DATA_W must be a non-zero multiple of BITS_PER_CLK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCEPT, SHIFT, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  crc_q, crc_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_crc_q, out_crc_d;

    logic [WIDTH-1:0]  crc_next;
    logic [DATA_W-1:0] shreg_next;
    logic [WIDTH-1:0]  crc_refl;

    // Fold the next BITS_PER_CLK message bits into the CRC in one cycle.
    always_comb begin
        logic msg_bit;
        logic fb;
        msg_bit    = 1'b0;
        fb         = 1'b0;
        crc_next   = crc_q;
        shreg_next = shreg_q;
        for (int i = 0; i < int'(BITS_PER_CLK); i++) begin
            if (REFIN) begin
                msg_bit    = shreg_next[0];
                shreg_next = shreg_next >> 1;
            end else begin
                msg_bit    = shreg_next[DATA_W-1];
                shreg_next = shreg_next << 1;
            end
            fb       = crc_next[WIDTH-1] ^ msg_bit;
            crc_next = (crc_next << 1) ^ (fb ? POLY : '0);
        end
    end

    // Optional bit reversal of the finished CRC before the final XOR.
    always_comb begin
        crc_refl = crc_next;
        if (REFOUT) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                crc_refl[i] = crc_next[WIDTH-1-i];
            end
        end
    end

    // Next-state logic for the control FSM and every registered output.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_crc_d   = out_crc_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    crc_d       = INIT;
                    out_valid_d = 1'b0;
                    state_d     = ACCEPT;
                end
            end
            ACCEPT: begin
                if (bus.in_valid && in_ready_q) begin
                    shreg_d = bus.in_data;
                    last_d  = bus.in_last;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                crc_d   = crc_next;
                shreg_d = shreg_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    if (last_q) begin
                        out_valid_d = 1'b1;
                        out_crc_d   = crc_refl ^ XOROUT;
                        state_d     = DONE;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == ACCEPT);
        busy_d     = (state_d == ACCEPT) || (state_d == SHIFT);
    end

    // State and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            crc_q       <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_crc_q   <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_crc_q   <= out_crc_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_crc   = out_crc_q;

endmodule
